// File: rtl/rice_pkg.sv
// Shared widths, types and constants for the Rice unmapping path.
package rice_pkg;

  localparam int SAMPLE_W = 10;
  localparam int J_MAX    = 32;
  localparam int BLK_W    = J_MAX * SAMPLE_W;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [SAMPLE_W-1:0] sym_t;
  typedef logic [BLK_W-1:0]    blk_t;

  localparam sample_t XMIN = {SAMPLE_W{1'b0}};
  localparam sample_t XMAX = {SAMPLE_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Symbol 0 sits in the MSBs of the block bus.
  function automatic sym_t get_sym(input blk_t data, input logic [4:0] k);
    return data[BLK_W-1 - int'(k)*SAMPLE_W -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/rice_inv_map.sv
// Combinational inverse of the prediction-error mapping: (predictor, mapped symbol) -> sample.
module rice_inv_map
  import rice_pkg::*;
(
  input  sample_t p_i,
  input  sym_t    d_i,
  output sample_t x_o
);

  sample_t                   lo_s;
  sample_t                   hi_s;
  sample_t                   theta_s;
  logic                      low_side_s;
  logic signed [SAMPLE_W+1:0] d_w_s;
  logic signed [SAMPLE_W+1:0] th_w_s;
  logic signed [SAMPLE_W+1:0] p_w_s;
  logic signed [SAMPLE_W+1:0] res_s;
  logic signed [SAMPLE_W+1:0] x_w_s;

  assign lo_s       = p_i - XMIN;
  assign hi_s       = XMAX - p_i;
  assign low_side_s = (lo_s <= hi_s);
  assign theta_s    = low_side_s ? lo_s : hi_s;

  assign d_w_s  = $signed({2'b00, d_i});
  assign th_w_s = $signed({2'b00, theta_s});
  assign p_w_s  = $signed({2'b00, p_i});

  // Residual recovery; symbols beyond 2*theta can only lie on the roomier side.
  always_comb begin
    res_s = '0;
    if (d_w_s <= (th_w_s <<< 1)) begin
      if (!d_i[0]) begin
        res_s = d_w_s >>> 1;
      end else begin
        res_s = -((d_w_s + 12'sd1) >>> 1);
      end
    end else if (low_side_s) begin
      res_s = d_w_s - th_w_s;
    end else begin
      res_s = th_w_s - d_w_s;
    end
  end

  assign x_w_s = p_w_s + res_s;

  // Saturation only matters for illegal symbol streams.
  always_comb begin
    x_o = x_w_s[SAMPLE_W-1:0];
    if (x_w_s < $signed({2'b00, XMIN})) begin
      x_o = XMIN;
    end else if (x_w_s > $signed({2'b00, XMAX})) begin
      x_o = XMAX;
    end else begin
      x_o = x_w_s[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/rice_unmapper.sv
// Accepts a block of mapped residuals and streams reconstructed samples one per cycle.
module rice_unmapper
  import rice_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [BLK_W-1:0]    blk_data,
  input  logic [5:0]          blk_j,
  input  logic                blk_ref,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                smp_last
);

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] jeff_q, jeff_d;
  blk_t       data_q, data_d;
  sample_t    pred_q, pred_d;
  sample_t    smp_data_q, smp_data_d;
  logic       smp_valid_q, smp_valid_d;
  logic       smp_last_q, smp_last_d;
  logic       blk_ready_q, blk_ready_d;

  logic       accept_s;
  logic [5:0] jeff_in_s;
  logic [5:0] idx_nxt_s;
  sample_t    map_p_s;
  sym_t       map_d_s;
  logic       bypass_s;
  sample_t    map_x_s;
  sample_t    x_s;

  assign accept_s  = (state_q == ST_IDLE) && blk_valid && blk_ready_q;
  assign jeff_in_s = (blk_j > 6'd32) ? 6'd32 : blk_j;
  assign idx_nxt_s = {1'b0, idx_q} + 6'd1;

  // In IDLE the mapper sees the incoming symbol 0; in RUN it precomputes the next sample.
  always_comb begin
    map_p_s  = pred_q;
    map_d_s  = get_sym(blk_data, 5'd0);
    bypass_s = blk_ref;
    if (state_q == ST_RUN) begin
      map_p_s  = smp_data_q;
      map_d_s  = get_sym(data_q, idx_nxt_s[4:0]);
      bypass_s = 1'b0;
    end else begin
      map_p_s  = pred_q;
      map_d_s  = get_sym(blk_data, 5'd0);
      bypass_s = blk_ref;
    end
  end

  rice_inv_map u_inv_map (
    .p_i (map_p_s),
    .d_i (map_d_s),
    .x_o (map_x_s)
  );

  assign x_s = bypass_s ? map_d_s : map_x_s;

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    jeff_d      = jeff_q;
    data_d      = data_q;
    pred_d      = pred_q;
    smp_data_d  = smp_data_q;
    smp_valid_d = smp_valid_q;
    smp_last_d  = smp_last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d = blk_data;
          jeff_d = jeff_in_s;
          if (jeff_in_s != 6'd0) begin
            state_d     = ST_RUN;
            idx_d       = 5'd0;
            smp_data_d  = x_s;
            smp_valid_d = 1'b1;
            smp_last_d  = (jeff_in_s == 6'd1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (smp_valid_q && smp_ready) begin
          pred_d = smp_data_q;
          if (idx_nxt_s < jeff_q) begin
            idx_d      = idx_nxt_s[4:0];
            smp_data_d = x_s;
            smp_last_d = ((idx_nxt_s + 6'd1) == jeff_q);
          end else begin
            smp_valid_d = 1'b0;
            smp_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        smp_valid_d = 1'b0;
        smp_last_d  = 1'b0;
      end
    endcase
    blk_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      jeff_q      <= 6'd0;
      data_q      <= '0;
      pred_q      <= XMIN;
      smp_data_q  <= {SAMPLE_W{1'b0}};
      smp_valid_q <= 1'b0;
      smp_last_q  <= 1'b0;
      blk_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      jeff_q      <= jeff_d;
      data_q      <= data_d;
      pred_q      <= pred_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      smp_last_q  <= smp_last_d;
      blk_ready_q <= blk_ready_d;
    end
  end

  assign blk_ready = blk_ready_q;
  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign smp_last  = smp_last_q;

endmodule

// File: tb/tb_rice_unmapper.sv
// Directed bench for rice_unmapper with hand-computed sample sequences.
module tb_rice_unmapper;
  import rice_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                blk_valid;
  logic                blk_ready;
  logic [BLK_W-1:0]    blk_data;
  logic [5:0]          blk_j;
  logic                blk_ref;
  logic                smp_valid;
  logic                smp_ready;
  logic [SAMPLE_W-1:0] smp_data;
  logic                smp_last;

  sample_t m_p, m_x;
  sym_t    m_d;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  rice_unmapper dut (
    .clk       (clk),
    .reset     (reset),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_j     (blk_j),
    .blk_ref   (blk_ref),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_data  (smp_data),
    .smp_last  (smp_last)
  );

  rice_inv_map u_ref_map (
    .p_i (m_p),
    .d_i (m_d),
    .x_o (m_x)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [BLK_W-1:0] pk(input int s[$]);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < s.size(); i++) r[BLK_W-1 - i*SAMPLE_W -: SAMPLE_W] = 10'(s[i]);
    return r;
  endfunction

  task automatic send_block(input logic [BLK_W-1:0] d, input logic [5:0] j, input logic r);
    int cyc;
    cyc = 0;
    blk_data  = d;
    blk_j     = j;
    blk_ref   = r;
    blk_valid = 1'b1;
    while (!blk_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("blk_ready_idle", blk_ready, 1);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = ~d;
    chk("latency1_valid", smp_valid, (j != 6'd0));
  endtask

  task automatic collect(input int n, input int jlen, input logic [3:0] pat);
    int k, c;
    logic pv, pr, pl;
    logic [SAMPLE_W-1:0] pd;
    k = 0; c = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    while (k < n && c < 400) begin
      smp_ready = pat[c % 4];
      if (pv && !pr) begin
        chk("hold_valid", smp_valid, 1);
        chk("hold_data", smp_data, pd);
        chk("hold_last", smp_last, pl);
      end
      if (smp_valid) chk("run_blk_ready", blk_ready, 0);
      if (smp_valid && smp_ready) begin
        chk("sample", smp_data, exp_q[k]);
        chk("last", smp_last, (k == jlen - 1));
        k++;
      end
      pv = smp_valid; pr = smp_ready; pd = smp_data; pl = smp_last;
      @(negedge clk);
      c++;
    end
    smp_ready = 1'b0;
    chk("xfer_count", k, n);
  endtask

  task automatic check_done();
    chk("done_valid", smp_valid, 0);
    chk("done_blk_ready", blk_ready, 1);
  endtask

  initial begin
    int s[$];
    reset = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_j = '0; blk_ref = 1'b0; smp_ready = 1'b0;
    m_p = '0; m_d = '0;

    // Reference mapper vectors, including range boundaries.
    m_p = 10'd5;    m_d = 10'd4;    #1 chk("map_5_4", m_x, 7);
    m_p = 10'd1020; m_d = 10'd9;    #1 chk("map_1020_9", m_x, 1014);
    m_p = 10'd0;    m_d = 10'd2;    #1 chk("map_0_2", m_x, 2);
    m_p = 10'd300;  m_d = 10'd1;    #1 chk("map_300_1", m_x, 299);
    m_p = 10'd0;    m_d = 10'd1023; #1 chk("map_0_1023", m_x, 1023);
    m_p = 10'd1023; m_d = 10'd1023; #1 chk("map_1023_1023", m_x, 0);

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_last", smp_last, 0);
    chk("rst_blk_ready", blk_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_blk_ready", blk_ready, 1);

    // Basic block with reference sample.
    send_block(pk('{5, 4, 3, 20}), 6'd4, 1'b1);
    exp_q = '{5, 7, 5, 20};
    collect(4, 4, 4'b1111);
    check_done();

    // High-side residual near the top of range.
    send_block(pk('{1020, 9}), 6'd2, 1'b1);
    exp_q = '{1020, 1014};
    collect(2, 2, 4'b1111);
    check_done();

    // Backpressure with ready pattern 1,0,0,1.
    send_block(pk('{500, 1, 1, 1, 1, 1}), 6'd6, 1'b1);
    exp_q = '{500, 499, 498, 497, 496, 495};
    collect(6, 6, 4'b1001);
    check_done();

    // Predictor persists across blocks; an empty block leaves it alone.
    send_block(pk('{300}), 6'd1, 1'b1);
    exp_q = '{300};
    collect(1, 1, 4'b1111);
    send_block(pk('{7}), 6'd0, 1'b0);
    @(negedge clk);
    chk("empty_blk_valid", smp_valid, 0);
    chk("empty_blk_ready", blk_ready, 1);
    send_block(pk('{1}), 6'd1, 1'b0);
    exp_q = '{299};
    collect(1, 1, 4'b1111);
    check_done();

    // Oversized count is clamped to 32 samples.
    s = '{100};
    for (int i = 1; i < 32; i++) s.push_back(2);
    exp_q = {};
    for (int i = 0; i < 32; i++) exp_q.push_back(100 + i);
    send_block(pk(s), 6'd45, 1'b1);
    collect(32, 32, 4'b1111);
    check_done();

    // Reset in the middle of a block.
    s = '{50};
    for (int i = 1; i < 10; i++) s.push_back(0);
    send_block(pk(s), 6'd10, 1'b1);
    exp_q = '{50, 50, 50};
    collect(3, 10, 4'b1111);
    chk("pre_rst_valid", smp_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", smp_valid, 0);
    chk("midrst_blk_ready", blk_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_after_blk_ready", blk_ready, 1);
    send_block(pk('{2}), 6'd1, 1'b0);
    exp_q = '{2};
    collect(1, 1, 4'b1111);
    check_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
